// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module      : uart_tx_pkg
// Description : Register offsets, STATUS bit positions and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  localparam logic [1:0] ADDR_TXDATA  = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_BAUDDIV = 2'd2;
  localparam logic [1:0] ADDR_RSVD    = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO, power-of-two depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  // A push while full is refused even if a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_periph.sv
// ============================================================================
// Module      : uart_tx_periph
// Description : Bus-mapped 8N1 UART transmitter with TX FIFO and baud divisor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_periph
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state_q;
  logic        tx_q;
  logic        ovf_q;
  logic [15:0] div_q;
  logic [15:0] div_lat_q;
  logic [15:0] baud_cnt_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic          bus_wr;
  logic          wr_txdata;
  logic          bit_end;
  logic          pop;
  logic          unused_wdata;

  assign bus_wr       = ce && we;
  assign wr_txdata    = bus_wr && (addr == ADDR_TXDATA);
  assign bit_end      = (baud_cnt_q == div_lat_q - 16'd1);
  assign pop          = !fifo_empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
  assign unused_wdata = ^wdata[31:16];

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_txdata),
    .wdata_i (wdata[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      div_q <= DEFAULT_DIV;
    end else begin
      if (wr_txdata && fifo_full) begin
        ovf_q <= 1'b1;
      end else if (bus_wr && (addr == ADDR_STATUS) && wdata[STAT_OVF]) begin
        ovf_q <= 1'b0;
      end
      if (bus_wr && (addr == ADDR_BAUDDIV)) begin
        div_q <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
      end
    end
  end

  // Divisor is latched on START entry so a mid-frame BAUDDIV write waits a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      div_lat_q  <= DEFAULT_DIV;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q    <= fifo_head;
            div_lat_q  <= div_q;
            baud_cnt_q <= '0;
            tx_q       <= 1'b0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            tx_q       <= shift_q[0];
            shift_q    <= shift_q >> 1;
            bit_cnt_q  <= '0;
            state_q    <= S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (pop) begin
              shift_q   <= fifo_head;
              div_lat_q <= div_q;
              tx_q      <= 1'b0;
              state_q   <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (ce) begin
      case (addr)
        ADDR_STATUS: begin
          rdata[STAT_BUSY]          = (state_q != S_IDLE);
          rdata[STAT_FULL]          = fifo_full;
          rdata[STAT_EMPTY]         = fifo_empty;
          rdata[STAT_OVF]           = ovf_q;
          rdata[STAT_CNT_LSB +: 4]  = 4'(fifo_count);
        end
        ADDR_BAUDDIV: rdata[15:0] = div_q;
        default:      rdata = '0;
      endcase
    end
  end

  assign tx  = tx_q;
  assign irq = fifo_empty && (state_q == S_IDLE);

endmodule

`default_nettype wire
